serial_pattern_gen: RTL and testbench
=====================================

// Module: serial_pattern_gen
// PURPOSE
//   Transmit-side companion to the serial sequence-detector FSMs (x_in -> y_out).
//   Latches a bit pattern and shifts it out MSB-first on x_out, one bit per clock,
//   optionally repeated with idle gaps. Drives detector x_in in system and in benches.
//   Moore machine: all outputs registered.
// PARAMETERS
//   PAT_W  8  pattern register width, max bits per transmission
//   LEN_W  4  width of length input, must satisfy 2**LEN_W > PAT_W
//   GAP_W  4  width of gap input and gap counter
// PORTS
//   CLK         in   1      clock, rising edge
//   Reset       in   1      async, active-low; 0 forces IDLE immediately
//   start       in   1      request; sampled only in IDLE
//   pattern     in   PAT_W  bits to send; bit length-1 is sent first
//   length      in   LEN_W  bits per transmission; legal range 1..PAT_W
//   repeat_cnt  in   4      extra transmissions; total sent = repeat_cnt+1
//   gap         in   GAP_W  idle cycles between transmissions; 0 = back-to-back
//   x_out       out  1      serial data; 0 whenever valid=0
//   valid       out  1      1 while x_out carries a pattern bit
//   busy        out  1      1 from accepted start through DONE cycle
//   done        out  1      one-cycle pulse after final bit
// BEHAVIOUR
//   Reset (Reset=0, async): state=IDLE, x_out=0, valid=0, busy=0, done=0, counters cleared.
//     Reset mid-operation aborts: no done pulse, no further bits.
//   States: IDLE, SEND, GAP, DONE (2-bit encoding).
//   IDLE: start=1 and 1<=length<=PAT_W at edge k -> latch pattern/length/repeat_cnt/gap
//     into internal registers, go SEND. x_out=pattern[length-1], valid=1, busy=1 from edge k.
//     Illegal length (0 or >PAT_W) -> start ignored, stay IDLE, no done.
//   SEND: bit i (i=0..length-1) = latched pattern[length-1-i], visible after edge k+i.
//     Inputs not re-sampled while busy; start while busy ignored.
//     After last bit:
//       reps left and gap>0  -> GAP
//       reps left and gap==0 -> restart SEND with next bit = pattern[length-1]
//       no reps left         -> DONE
//   GAP: x_out=0, valid=0, busy=1 for exactly gap cycles. Then SEND, first bit restarts.
//   DONE: done=1, busy=1, valid=0, x_out=0 for one cycle, then IDLE (busy=0, done=0).
//     start during the DONE cycle is ignored.
//   Cycle counts
//     single transmission, no repeat: length valid cycles + 1 DONE cycle
//     total busy cycles = (repeat_cnt+1)*length + repeat_cnt*gap + 1
//   Next start accepted on the first IDLE cycle after DONE.
//   Counters saturate at zero; no wrap. repeat_cnt=15 sends 16 transmissions.
// TESTING
//   1 Reset=0 for 2 cycles, all inputs random -> x_out=0, valid=0, busy=0, done=0.
//     Release Reset: still idle.
//   2 pattern=8'b1011_0110, length=8, repeat_cnt=0, gap=0, start pulse
//     -> x_out 1,0,1,1,0,1,1,0 with valid=1 for 8 cycles; done=1 in cycle 9;
//        busy=0 in cycle 10.
//   3 pattern=8'bxxxx_x101, length=3, repeat_cnt=1, gap=2
//     -> 1,0,1 valid; 2 cycles valid=0 x_out=0; 1,0,1 valid; done pulse;
//        busy high 9 cycles.
//   4 pattern=8'b0000_0011, length=2, repeat_cnt=2, gap=0
//     -> 1,1 repeated: 6 consecutive valid=1 cycles (x_out 1,1,1,1,1,1); then done.
//   5 start with length=0, then with length=9 -> no busy, no valid, no done.
//     start held high during SEND -> transmission unchanged, no restart.
//   6 Reset=0 asynchronously during bit 4 of case 2 -> outputs 0 before next edge,
//     no done pulse. After release, a new start of case 3 -> exact case 3 output.
//   Bench drives vectors from a file: {Reset,start,expected x_out,expected valid}.
//   Compare on negedge CLK; print mismatches.

Source files
------------

// File: rtl/serial_pattern_gen_if.sv
// Bundle of the pattern generator's request/configuration inputs and its
// serial outputs. The master side supplies a request; the slave side
// (the generator) answers with the serial stream and status.
interface serial_pattern_gen_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int GAP_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] length;
    logic [3:0]       repeat_cnt;
    logic [GAP_W-1:0] gap;
    logic             x_out;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, length, repeat_cnt, gap,
        input  x_out, valid, busy, done
    );

    modport slave (
        input  start, pattern, length, repeat_cnt, gap,
        output x_out, valid, busy, done
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: latches a pattern and shifts it out MSB-first,
// one bit per clock, optionally repeated with idle gaps between copies.
// Moore machine; every output comes straight from a register.
module serial_pattern_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int GAP_W = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    serial_pattern_gen_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    state_t           r_state,     w_state_next;
    logic [PAT_W-1:0] r_pat,       w_pat_next;      // pattern, left-aligned
    logic [PAT_W-1:0] r_shift,     w_shift_next;    // bits still to send
    logic [LEN_W-1:0] r_len,       w_len_next;
    logic [LEN_W-1:0] r_bits_left, w_bits_next;     // bits after the one on x_out
    logic [3:0]       r_reps,      w_reps_next;
    logic [GAP_W-1:0] r_gap,       w_gap_next;
    logic [GAP_W-1:0] r_gap_cnt,   w_gap_cnt_next;
    logic             r_x_out,     w_x_next;
    logic             r_valid,     w_valid_next;
    logic             r_busy,      w_busy_next;
    logic             r_done,      w_done_next;

    logic             w_len_ok;
    logic [LEN_W-1:0] w_shamt;
    logic [PAT_W-1:0] w_aligned;

    // Left-align the requested bits so the first bit to send sits at the MSB;
    // the shift amount cannot underflow once the length is known legal.
    assign w_len_ok  = (bus.length != '0) && (bus.length <= PAT_W_L);
    assign w_shamt   = PAT_W_L - bus.length;
    assign w_aligned = bus.pattern << w_shamt;

    assign bus.x_out = r_x_out;
    assign bus.valid = r_valid;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

    // State and datapath registers; reset aborts any transmission at once.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_pat       <= '0;
            r_shift     <= '0;
            r_len       <= '0;
            r_bits_left <= '0;
            r_reps      <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_x_out     <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pat       <= w_pat_next;
            r_shift     <= w_shift_next;
            r_len       <= w_len_next;
            r_bits_left <= w_bits_next;
            r_reps      <= w_reps_next;
            r_gap       <= w_gap_next;
            r_gap_cnt   <= w_gap_cnt_next;
            r_x_out     <= w_x_next;
            r_valid     <= w_valid_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    // Next-state and next-output logic; outputs default to the idle values.
    always_comb begin
        w_state_next   = r_state;
        w_pat_next     = r_pat;
        w_shift_next   = r_shift;
        w_len_next     = r_len;
        w_bits_next    = r_bits_left;
        w_reps_next    = r_reps;
        w_gap_next     = r_gap;
        w_gap_cnt_next = r_gap_cnt;
        w_x_next       = 1'b0;
        w_valid_next   = 1'b0;
        w_busy_next    = 1'b0;
        w_done_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Illegal lengths leave the request unanswered.
                if (bus.start && w_len_ok) begin
                    w_state_next = S_SEND;
                    w_pat_next   = w_aligned;
                    w_shift_next = w_aligned << 1;
                    w_len_next   = bus.length;
                    w_bits_next  = bus.length - LEN_W'(1);
                    w_reps_next  = bus.repeat_cnt;
                    w_gap_next   = bus.gap;
                    w_x_next     = w_aligned[PAT_W-1];
                    w_valid_next = 1'b1;
                    w_busy_next  = 1'b1;
                end
            end

            S_SEND: begin
                w_busy_next = 1'b1;
                if (r_bits_left != '0) begin
                    w_x_next     = r_shift[PAT_W-1];
                    w_shift_next = r_shift << 1;
                    w_bits_next  = r_bits_left - LEN_W'(1);
                    w_valid_next = 1'b1;
                end else if (r_reps != 4'd0) begin
                    w_reps_next = r_reps - 4'd1;
                    if (r_gap != '0) begin
                        w_state_next   = S_GAP;
                        w_gap_cnt_next = r_gap;
                    end else begin
                        // Back-to-back: first bit of the next copy follows directly.
                        w_x_next     = r_pat[PAT_W-1];
                        w_shift_next = r_pat << 1;
                        w_bits_next  = r_len - LEN_W'(1);
                        w_valid_next = 1'b1;
                    end
                end else begin
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                end
            end

            S_GAP: begin
                w_busy_next = 1'b1;
                if (r_gap_cnt > GAP_W'(1)) begin
                    w_gap_cnt_next = r_gap_cnt - GAP_W'(1);
                end else begin
                    w_state_next   = S_SEND;
                    w_gap_cnt_next = '0;
                    w_x_next       = r_pat[PAT_W-1];
                    w_shift_next   = r_pat << 1;
                    w_bits_next    = r_len - LEN_W'(1);
                    w_valid_next   = 1'b1;
                end
            end

            S_DONE: begin
                // Start during this cycle is deliberately not looked at.
                w_state_next = S_IDLE;
            end

            default: w_state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen. Expected per-cycle outputs
// {x_out, valid, busy, done} are built from the transmission rules as a list
// of bits, gap cycles and a final done cycle, then compared on the falling edge.
module tb_serial_pattern_gen;
    logic CLK   = 1'b0;
    logic Reset = 1'b1;

    serial_pattern_gen_if bus ();

    serial_pattern_gen dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [3:0] exp_q[$];

    function automatic logic [3:0] observed();
        return {bus.x_out, bus.valid, bus.busy, bus.done};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed {x,v,b,d}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic rand_inputs();
        bus.pattern    = 8'($urandom);
        bus.length     = 4'($urandom);
        bus.repeat_cnt = 4'($urandom);
        bus.gap        = 4'($urandom);
    endtask

    // Expected outputs for one accepted request, starting with the cycle
    // after the accepting edge and ending with one idle cycle.
    task automatic build(input logic [7:0] pat, input int len, input int rep, input int gap);
        exp_q.delete();
        for (int t = 0; t <= rep; t++) begin
            for (int i = 0; i < len; i++)
                exp_q.push_back({pat[len-1-i], 1'b1, 1'b1, 1'b0});
            if (t < rep)
                for (int g = 0; g < gap; g++)
                    exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0000);
    endtask

    // Issue one request; with hold=1, start stays high until the idle cycle.
    task automatic run(input string name, input logic [7:0] pat, input int len,
                       input int rep, input int gap, input bit hold);
        int n;
        build(pat, len, rep, gap);
        n = exp_q.size();
        @(negedge CLK);
        bus.start      = 1'b1;
        bus.pattern    = pat;
        bus.length     = 4'(len);
        bus.repeat_cnt = 4'(rep);
        bus.gap        = 4'(gap);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check($sformatf("%s[%0d]", name, i), observed(), exp_q[i]);
            rand_inputs();
            bus.start = hold && (i < n - 1);
        end
        $display("txn %s pat=%b len=%0d rep=%0d gap=%0d hold=%0d cycles=%0d",
                 name, pat, len, rep, gap, hold, n);
    endtask

    initial begin
        // Reset with random inputs and start asserted.
        rand_inputs();
        bus.start = 1'b1;
        Reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check($sformatf("reset[%0d]", i), observed(), 4'b0000);
            rand_inputs();
        end
        bus.start = 1'b0;
        Reset = 1'b1;
        @(negedge CLK);
        check("post_reset_idle", observed(), 4'b0000);

        // Directed cases.
        run("case2", 8'b1011_0110, 8, 0, 0, 1'b0);
        run("case3", 8'b1100_0101, 3, 1, 2, 1'b0);
        run("case4", 8'b0000_0011, 2, 2, 0, 1'b0);
        run("hold_start", 8'b1001_1101, 5, 1, 1, 1'b1);
        run("len1_rep15", 8'b1111_1111, 1, 15, 1, 1'b0);

        // Illegal lengths: no response at all.
        @(negedge CLK);
        bus.start = 1'b1; bus.length = 4'd0; bus.repeat_cnt = 4'd1; bus.gap = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("len0[%0d]", i), observed(), 4'b0000);
        end
        bus.length = 4'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("len9[%0d]", i), observed(), 4'b0000);
        end
        bus.length = 4'd15;
        @(negedge CLK);
        check("len15", observed(), 4'b0000);
        bus.start = 1'b0;
        $display("txn illegal_lengths 0/9/15 ignored");

        // Asynchronous reset during the fourth bit of case 2.
        @(negedge CLK);
        bus.start = 1'b1; bus.pattern = 8'b1011_0110; bus.length = 4'd8;
        bus.repeat_cnt = 4'd0; bus.gap = 4'd0;
        @(posedge CLK);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        check("pre_reset_bit4", observed(), 4'b1110);
        Reset = 1'b0;
        #1;
        check("async_reset", observed(), 4'b0000);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check($sformatf("reset_hold[%0d]", i), observed(), 4'b0000);
        end
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("after_abort[%0d]", i), observed(), 4'b0000);
        end
        $display("txn async_reset abort checked");
        run("case3_after_reset", 8'b0010_1101, 3, 1, 2, 1'b0);

        // Randomized requests against the model.
        for (int t = 0; t < 20; t++) begin
            run($sformatf("rand%0d", t), 8'($urandom), int'($urandom_range(1, 8)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
